cp0_timer: RTL and testbench

CP0 Count/Compare timer for the XUM MIPS32 pipelined core. Holds the architectural Count (CP0 reg 9) and Compare (CP0 reg 11) registers, increments Count at a divided clock rate, and raises the timer interrupt (Cause.IP7) when Count reaches Compare. It sits inside CP0 and receives MTC0 writes and MFC0 reads from the CP0 register decoder. Its equality check is the sequential consumer of the same A==B compare that feeds branch resolution.

---
 rtl/cp0_timer_pkg.sv | 26 ++
 rtl/Compare.sv | 16 +
 rtl/cp0_timer_prescaler.sv | 46 ++++
 rtl/cp0_timer.sv | 110 +++++++++++
 tb/tb_cp0_timer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_timer_pkg
//  Brief    : Shared CP0 constants and types used by the Count/Compare timer.
//  Revision : 1.0 - initial release
// ============================================================================
package cp0_timer_pkg;

  // CP0 register indices handled by the timer
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;

  // Position of IP7 (timer interrupt) inside the Cause register
  localparam int unsigned CP0_CAUSE_IP7 = 15;

  // Core clocks per Count increment unless overridden
  localparam int unsigned CP0_COUNT_DIV_DEFAULT = 2;

  // Read-select encoding for MFC0 accesses to the timer
  typedef enum logic {
    RD_COUNT   = 1'b0,
    RD_COMPARE = 1'b1
  } rd_sel_e;

endpackage
`default_nettype wire

// File: rtl/Compare.sv
`default_nettype none
// ============================================================================
//  Module   : Compare
//  Brief    : 32-bit equality comparator shared with branch resolution.
//  Revision : 1.0 - initial release
// ============================================================================
module Compare (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        EQ
);

  assign EQ = (A == B);

endmodule
`default_nettype wire

// File: rtl/cp0_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_timer_prescaler
//  Brief    : Divides the core clock down to the Count increment rate.
//             Holds while disabled, restarts from zero on a Count write.
//  Revision : 1.0 - initial release
// ============================================================================
module cp0_timer_prescaler #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  // A one-bit counter is kept even for COUNT_DIV=1; it simply stays at zero
  localparam int unsigned       DIV_W   = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             at_max;

  assign at_max = (div_cnt == DIV_MAX);

  // A write to Count owns the cycle, so the increment it would have produced is lost
  assign tick = enable & at_max & ~clear;

  // Prescale counter: clear on Count write, wrap at DIV_MAX, hold when disabled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (enable) begin
      if (at_max) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_timer
//  Brief    : CP0 Count/Compare timer. Count increments at a divided rate,
//             timer_irq (Cause.IP7) latches when Count changes into equality
//             with Compare and clears on a Compare write.
//  Revision : 1.0 - initial release
// ============================================================================
module cp0_timer
  import cp0_timer_pkg::*;
#(
  parameter int unsigned COUNT_DIV = CP0_COUNT_DIV_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        count_disable,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_irq
);

  logic    tick;
  logic    cnt_upd;
  logic    cnt_eq;
  logic    match;
  rd_sel_e sel;

  assign sel = rd_sel_e'(rd_sel);

  cp0_timer_prescaler #(
    .COUNT_DIV (COUNT_DIV)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (~count_disable),
    .clear  (wr_count),
    .tick   (tick)
  );

  Compare u_compare (
    .A  (count),
    .B  (compare),
    .EQ (cnt_eq)
  );

  // Only a Count that just changed may raise the interrupt; static equality is ignored
  assign match = cnt_upd & cnt_eq;

  // Count register: software write beats the prescaler increment
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (wr_count) begin
      count <= wr_data;
    end else if (tick) begin
      count <= count + 32'd1;
    end
  end

  // Compare register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      compare <= '0;
    end else if (wr_compare) begin
      compare <= wr_data;
    end
  end

  // One-cycle marker that Count was loaded on the previous edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_upd <= 1'b0;
    end else begin
      cnt_upd <= wr_count | tick;
    end
  end

  // Interrupt latch: a Compare write clears it and wins over a same-cycle match
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_irq <= 1'b0;
    end else if (wr_compare) begin
      timer_irq <= 1'b0;
    end else if (match) begin
      timer_irq <= 1'b1;
    end
  end

  // MFC0 read port: samples register values from before any same-cycle write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= (sel == RD_COMPARE) ? compare : count;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cp0_timer
//  Brief    : Self-checking bench for cp0_timer with a behavioural model,
//             directed scenarios and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_timer;

  localparam int unsigned COUNT_DIV = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        count_disable = 1'b0;
  logic        wr_count = 1'b0;
  logic        wr_compare = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic        rd_sel = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_irq;

  int n_pass  = 0;
  int n_total = 0;
  bit run_chk = 1'b0;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) dut (
    .clock         (clock),
    .reset         (reset),
    .count_disable (count_disable),
    .wr_count      (wr_count),
    .wr_compare    (wr_compare),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .rd_sel        (rd_sel),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .count         (count),
    .compare       (compare),
    .timer_irq     (timer_irq)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Behavioural model: architectural registers plus the number of enabled
  // edges seen since Count last changed, and whether Count just changed.
  // ---------------------------------------------------------------------------
  logic [31:0] m_count, m_compare, m_rd_data;
  logic        m_irq, m_rd_valid, m_changed;
  int unsigned m_enabled_edges;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_count = 0; m_compare = 0; m_rd_data = 0;
      m_irq = 0; m_rd_valid = 0; m_changed = 0; m_enabled_edges = 0;
    end else begin
      bit hit;
      bit changed_now;
      hit = m_changed && (m_count == m_compare);
      if (rd_en) m_rd_data = rd_sel ? m_compare : m_count;
      m_rd_valid = rd_en;
      changed_now = 0;
      if (wr_count) begin
        m_count = wr_data;
        m_enabled_edges = 0;
        changed_now = 1;
      end else if (!count_disable) begin
        m_enabled_edges++;
        if (m_enabled_edges == COUNT_DIV) begin
          m_enabled_edges = 0;
          m_count = m_count + 1;
          changed_now = 1;
        end
      end
      if (wr_compare) begin
        m_compare = wr_data;
        m_irq = 0;
      end else if (hit) begin
        m_irq = 1;
      end
      m_changed = changed_now;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clock) begin
    if (run_chk) begin
      chk("count",     count,            m_count);
      chk("compare",   compare,          m_compare);
      chk("timer_irq", {31'd0, timer_irq}, {31'd0, m_irq});
      chk("rd_valid",  {31'd0, rd_valid},  {31'd0, m_rd_valid});
      chk("rd_data",   rd_data,          m_rd_data);
    end
  end

  // Inputs change 1 time unit after a rising edge
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input bit wc, input bit wcmp, input logic [31:0] d,
                       input bit re, input bit rs, input bit dis);
    wr_count = wc; wr_compare = wcmp; wr_data = d;
    rd_en = re; rd_sel = rs; count_disable = dis;
  endtask

  initial begin
    // Reset
    cyc(3);
    reset = 1'b1;
    run_chk = 1'b1;
    chk("rst_count", count, 32'd0);
    chk("rst_irq", {31'd0, timer_irq}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);

    // Free-run 10 cycles, then read Count
    cyc(10);
    chk("run10_count", count, 32'd5);
    chk("run10_model", m_count, 32'd5);
    chk("run10_irq", {31'd0, timer_irq}, 32'd0);
    drive(0, 0, 0, 1, 0, 0);
    cyc(1);
    drive(0, 0, 0, 0, 0, 0);
    chk("rd_count_data", rd_data, 32'd5);
    chk("rd_count_valid", {31'd0, rd_valid}, 32'd1);
    cyc(1);
    chk("rd_hold_valid", {31'd0, rd_valid}, 32'd0);
    chk("rd_hold_data", rd_data, 32'd5);

    // Match through increments, then clear with a Compare write
    drive(0, 1, 32'h10, 0, 0, 0); cyc(1);
    drive(1, 0, 32'h0E, 0, 0, 0); cyc(1);
    drive(0, 0, 0, 0, 0, 0);
    cyc(4);
    chk("inc_reach", count, 32'h10);
    chk("inc_irq_pre", {31'd0, timer_irq}, 32'd0);
    cyc(1);
    chk("inc_irq_set", {31'd0, timer_irq}, 32'd1);
    cyc(6);
    chk("inc_irq_sticky", {31'd0, timer_irq}, 32'd1);
    drive(0, 1, 32'h20, 0, 0, 0); cyc(1);
    drive(0, 0, 0, 0, 0, 0);
    chk("cmp_clear_irq", {31'd0, timer_irq}, 32'd0);
    chk("cmp_clear_val", compare, 32'h20);

    // Wrap-around into Compare = 0
    drive(0, 1, 32'h0, 0, 0, 0); cyc(1);
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0); cyc(1);
    drive(0, 0, 0, 0, 0, 0);
    cyc(2);
    chk("wrap_count", count, 32'h0);
    chk("wrap_irq_pre", {31'd0, timer_irq}, 32'd0);
    cyc(1);
    chk("wrap_irq_set", {31'd0, timer_irq}, 32'd1);

    // Match through a Count write that collides with a tick
    drive(0, 1, 32'h30, 0, 0, 0); cyc(1);
    drive(0, 0, 0, 0, 0, 0); cyc(1);
    drive(1, 0, 32'h30, 0, 0, 0); cyc(1);
    drive(0, 0, 0, 0, 0, 0);
    chk("wrtick_count", count, 32'h30);
    cyc(1);
    chk("wrmatch_irq", {31'd0, timer_irq}, 32'd1);
    chk("wrtick_drop", count, 32'h30);

    // Match and Compare write in the same cycle
    drive(0, 1, 32'h40, 0, 0, 0); cyc(1);
    drive(1, 0, 32'h3F, 0, 0, 0); cyc(1);
    drive(0, 0, 0, 0, 0, 0); cyc(2);
    chk("coll_count", count, 32'h40);
    drive(0, 1, 32'h100, 0, 0, 0); cyc(1);
    drive(0, 0, 0, 0, 0, 0);
    chk("coll_irq", {31'd0, timer_irq}, 32'd0);
    chk("coll_compare", compare, 32'h100);
    cyc(3);
    chk("coll_irq_later", {31'd0, timer_irq}, 32'd0);
    chk("coll_count_later", count, 32'h42);

    // Count disabled for 8 cycles
    drive(0, 0, 0, 0, 0, 1); cyc(8);
    drive(0, 0, 0, 0, 0, 0);
    chk("dis_count", count, 32'h42);
    chk("dis_irq", {31'd0, timer_irq}, 32'd0);

    // Asynchronous reset mid-count
    cyc(3);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", count, 32'd0);
    chk("arst_compare", compare, 32'd0);
    chk("arst_rd_data", rd_data, 32'd0);
    chk("arst_irq", {31'd0, timer_irq}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Randomized traffic, with writes steered near the current values
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [31:0] d;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 1) == 1) begin
        if (r < 8) d = m_compare - $urandom_range(0, 3);
        else       d = m_count + $urandom_range(0, 4);
      end else begin
        d = $urandom;
      end
      drive(r < 8, (r >= 8 && r < 16) || r == 50, d,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
      end else begin
        cyc(1);
      end
    end

    drive(0, 0, 0, 0, 0, 0);
    cyc(2);
    run_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
